// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and memory geometry.
// Optional feature macro used by the LSU: LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

    localparam int DMEM_WORDS_DEF = 2048;
    localparam int WADDR_W_DEF    = 11;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } lsu_state_e;

    // Unsigned load variants have no store counterpart.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and data-memory signal bundle for the load/store unit.
// The master modport is the LSU itself; slave is the execute stage plus data memory.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] result;
    logic [31:0] read_b;
    logic [31:0] read_data;

    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, read_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_read, mem_write, result, read_b
    );

    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, read_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_read, mem_write, result, read_b
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/half extraction with extension, and sub-word store merge
// into the word read back from data memory.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_shift = i_rdata >> {i_offset, 3'b000};
        w_byte  = w_shift[7:0];
        w_half  = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load = {24'd0, w_byte};
            F3_H:    o_load = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load = {16'd0, w_half};
            default: o_load = i_rdata;
        endcase
    end

    // Untouched lanes keep the memory contents since dmem has no byte enables.
    always_comb begin
        o_merged = i_rdata;
        case (i_funct3)
            F3_B: o_merged[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
            F3_H: begin
                if (i_offset[1]) o_merged[31:16] = i_wdata[15:0];
                else             o_merged[15:0]  = i_wdata[15:0];
            end
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, drives a word-indexed data memory, RMW for sub-word stores.
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned H/W accesses as errors instead of aligning down.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DMEM_WORDS = DMEM_WORDS_DEF,
    parameter int WADDR_W    = WADDR_W_DEF
) (
    input  logic   clk,
    input  logic   reset,
    lsu_if.master  bus
);

    localparam logic [32:0] ADDR_LIMIT = 33'(DMEM_WORDS) << 2;

    lsu_state_e         r_state;
    lsu_state_e         w_next;
    logic               r_write;
    logic [2:0]         r_funct3;
    logic [1:0]         r_offset;
    logic [WADDR_W-1:0] r_windex;
    logic [31:0]        r_wdata;
    logic [31:0]        r_wbuf;
    logic [31:0]        r_rdata;
    logic               r_err;

    logic               w_accept;
    logic               w_range_err;
    logic               w_f3_err;
    logic               w_err;
    logic [1:0]         w_offset;
    logic               w_is_sw;
    logic [31:0]        w_load;
    logic [31:0]        w_merged;

    assign w_accept    = bus.req_valid & bus.req_ready;
    assign w_range_err = ({1'b0, bus.req_addr} >= ADDR_LIMIT);
    assign w_f3_err    = !f3_legal(bus.req_write, bus.req_funct3);
    assign w_is_sw     = bus.req_write && (bus.req_funct3 == F3_W);

    always_comb begin
        case (bus.req_funct3)
            F3_W:         w_offset = 2'b00;
            F3_H, F3_HU:  w_offset = {bus.req_addr[1], 1'b0};
            default:      w_offset = bus.req_addr[1:0];
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = (w_offset != bus.req_addr[1:0]);
    assign w_err      = w_f3_err | w_range_err | w_misalign;
`else
    assign w_err      = w_f3_err | w_range_err;
`endif

    lsu_align u_align (
        .i_funct3 (r_funct3),
        .i_offset (r_offset),
        .i_rdata  (bus.read_data),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_err)        w_next = RESP;
                    else if (w_is_sw) w_next = WR;
                    else              w_next = RD;
                end
            end
            RD:      w_next = CAP;
            CAP:     w_next = r_write ? WR : RESP;
            WR:      w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request latch and data registers; rsp_rdata only changes on the edge that enters RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_write  <= 1'b0;
            r_funct3 <= 3'd0;
            r_offset <= 2'd0;
            r_windex <= '0;
            r_wdata  <= 32'd0;
            r_wbuf   <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write  <= bus.req_write;
                        r_funct3 <= bus.req_funct3;
                        r_offset <= w_offset;
                        r_wdata  <= bus.req_wdata;
                        r_err    <= w_err;
                        if (w_err) begin
                            r_rdata <= 32'd0;
                        end else begin
                            r_windex <= bus.req_addr[WADDR_W+1:2];
                            if (w_is_sw) r_wbuf <= bus.req_wdata;
                        end
                    end
                end
                CAP: begin
                    if (r_write) r_wbuf  <= w_merged;
                    else         r_rdata <= w_load;
                end
                WR:      r_rdata <= 32'd0;
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (r_state == IDLE) & reset;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_err   = (r_state == RESP) & r_err;
    assign bus.rsp_rdata = r_rdata;
    assign bus.mem_read  = (r_state == RD);
    assign bus.mem_write = (r_state == WR);
    assign bus.result    = {{(32-WADDR_W){1'b0}}, r_windex};
    assign bus.read_b    = r_wbuf;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural word-indexed data memory.
// Honours LSU_MISALIGN_TRAP_EN for the misaligned-access expectations.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_if bus();

    load_store_unit #(.DMEM_WORDS(2048), .WADDR_W(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] dmem [0:2047];
    logic        pokeEn;
    logic [10:0] pokeIdx;
    logic [31:0] pokeVal;

    // Data memory: registered read, write on strobe, plus a backdoor preload port.
    always @(posedge clk) begin
        if (pokeEn)             dmem[pokeIdx] <= pokeVal;
        else if (bus.mem_write) dmem[bus.result[10:0]] <= bus.read_b;
        if (bus.mem_read)       bus.read_data <= dmem[bus.result[10:0]];
    end

    int checks = 0;
    int failures = 0;
    int bothSeen = 0;

    always @(negedge clk) begin
        if (bus.mem_read && bus.mem_write) bothSeen++;
    end

    int          lat, rdCnt, wrCnt;
    logic [31:0] rdIdx, wrIdx, wrData, gotRdata, heldRdata;
    logic        gotErr, validAfter, readyBefore;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic pokeMem(input logic [10:0] idx, input logic [31:0] val);
        @(negedge clk);
        pokeEn = 1'b1; pokeIdx = idx; pokeVal = val;
        @(posedge clk);
        #1 pokeEn = 1'b0;
    endtask

    // Issue one request and record strobes, latency and response up to a 10-cycle bound.
    task automatic applyStimulus(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        @(negedge clk);
        readyBefore = bus.req_ready;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0; rdCnt = 0; wrCnt = 0; gotErr = 1'b0;
        rdIdx = 32'hFFFF_FFFF; wrIdx = 32'hFFFF_FFFF; wrData = 32'hFFFF_FFFF; gotRdata = 32'hFFFF_FFFF;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            if (bus.mem_read)  begin rdCnt++; rdIdx = bus.result; end
            if (bus.mem_write) begin wrCnt++; wrIdx = bus.result; wrData = bus.read_b; end
            if (bus.rsp_valid) begin lat = c; gotErr = bus.rsp_err; gotRdata = bus.rsp_rdata; end
        end
        @(negedge clk);
        validAfter = bus.rsp_valid;
        heldRdata  = bus.rsp_rdata;
    endtask

    task automatic checkRequest(input string tag, input int expLat, input logic expErr, input int expRd,
                                input int expWr, input logic [31:0] expRdata);
        checkOutput({tag, ".ready"}, 32'(readyBefore), 32'd1);
        checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, ".err"}, 32'(gotErr), 32'(expErr));
        checkOutput({tag, ".reads"}, 32'(rdCnt), 32'(expRd));
        checkOutput({tag, ".writes"}, 32'(wrCnt), 32'(expWr));
        checkOutput({tag, ".rdata"}, gotRdata, expRdata);
        checkOutput({tag, ".pulse"}, 32'(validAfter), 32'd0);
        checkOutput({tag, ".held"}, heldRdata, expRdata);
    endtask

    initial begin
        reset = 1'b0;
        pokeEn = 1'b0; pokeIdx = '0; pokeVal = '0;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = F3_W;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h0;

        repeat (3) @(negedge clk);
        checkOutput("rst.req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst.rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("rst.mem_read", 32'(bus.mem_read), 32'd0);
        checkOutput("rst.mem_write", 32'(bus.mem_write), 32'd0);
        checkOutput("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
        checkOutput("rst.result", bus.result, 32'd0);
        checkOutput("rst.read_b", bus.read_b, 32'd0);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rel.req_ready", 32'(bus.req_ready), 32'd1);

        pokeMem(11'd4, 32'hDEAD_BEEF);
        applyStimulus(1'b0, F3_W, 32'h10, 32'h0);
        checkRequest("lw10", 3, 1'b0, 1, 0, 32'hDEAD_BEEF);
        checkOutput("lw10.index", rdIdx, 32'd4);

        pokeMem(11'd4, 32'h80FF_1234);
        applyStimulus(1'b0, F3_B, 32'h13, 32'h0);
        checkRequest("lb13", 3, 1'b0, 1, 0, 32'hFFFF_FF80);
        applyStimulus(1'b0, F3_BU, 32'h13, 32'h0);
        checkRequest("lbu13", 3, 1'b0, 1, 0, 32'h0000_0080);
        applyStimulus(1'b0, F3_H, 32'h12, 32'h0);
        checkRequest("lh12", 3, 1'b0, 1, 0, 32'hFFFF_80FF);
        applyStimulus(1'b0, F3_HU, 32'h10, 32'h0);
        checkRequest("lhu10", 3, 1'b0, 1, 0, 32'h0000_1234);
        applyStimulus(1'b0, F3_B, 32'h11, 32'h0);
        checkRequest("lb11", 3, 1'b0, 1, 0, 32'h0000_0012);

        pokeMem(11'd4, 32'h1122_3344);
        applyStimulus(1'b1, F3_B, 32'h11, 32'hFFFF_FFAA);
        checkRequest("sb11", 4, 1'b0, 1, 1, 32'h0);
        checkOutput("sb11.rd_index", rdIdx, 32'd4);
        checkOutput("sb11.wr_index", wrIdx, 32'd4);
        checkOutput("sb11.read_b", wrData, 32'h1122_AA44);
        applyStimulus(1'b0, F3_W, 32'h10, 32'h0);
        checkRequest("lw10.after_sb", 3, 1'b0, 1, 0, 32'h1122_AA44);

        applyStimulus(1'b1, F3_H, 32'h12, 32'h0000_5566);
        checkRequest("sh12", 4, 1'b0, 1, 1, 32'h0);
        checkOutput("sh12.read_b", wrData, 32'h5566_AA44);

        applyStimulus(1'b1, F3_W, 32'h20, 32'h0BAD_F00D);
        checkRequest("sw20", 2, 1'b0, 0, 1, 32'h0);
        checkOutput("sw20.wr_index", wrIdx, 32'd8);
        checkOutput("sw20.read_b", wrData, 32'h0BAD_F00D);
        applyStimulus(1'b0, F3_W, 32'h20, 32'h0);
        checkRequest("lw20", 3, 1'b0, 1, 0, 32'h0BAD_F00D);

        pokeMem(11'd2047, 32'hCAFE_F00D);
        applyStimulus(1'b0, F3_W, 32'h1FFC, 32'h0);
        checkRequest("lw_last", 3, 1'b0, 1, 0, 32'hCAFE_F00D);
        checkOutput("lw_last.index", rdIdx, 32'h7FF);

`ifdef LSU_MISALIGN_TRAP_EN
        applyStimulus(1'b0, F3_W, 32'h12, 32'h0);
        checkRequest("lw12.trap", 1, 1'b1, 0, 0, 32'h0);
        applyStimulus(1'b0, F3_H, 32'h13, 32'h0);
        checkRequest("lh13.trap", 1, 1'b1, 0, 0, 32'h0);
`else
        applyStimulus(1'b0, F3_W, 32'h12, 32'h0);
        checkRequest("lw12.align", 3, 1'b0, 1, 0, 32'h5566_AA44);
        checkOutput("lw12.index", rdIdx, 32'd4);
        applyStimulus(1'b0, F3_H, 32'h13, 32'h0);
        checkRequest("lh13.align", 3, 1'b0, 1, 0, 32'h0000_5566);
`endif

        applyStimulus(1'b0, F3_W, 32'h2000, 32'h0);
        checkRequest("lw_oor", 1, 1'b1, 0, 0, 32'h0);
        applyStimulus(1'b0, F3_W, 32'h8000_0010, 32'h0);
        checkRequest("lw_wrap", 1, 1'b1, 0, 0, 32'h0);
        applyStimulus(1'b0, 3'b011, 32'h10, 32'h0);
        checkRequest("ld_f3_011", 1, 1'b1, 0, 0, 32'h0);
        applyStimulus(1'b1, F3_BU, 32'h10, 32'h1234_5678);
        checkRequest("st_f3_100", 1, 1'b1, 0, 0, 32'h0);

        // Sub-word store aborted by reset while in CAP.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = F3_H;
        bus.req_addr = 32'h12; bus.req_wdata = 32'h0000_7777;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("abort.rd_strobe", 32'(bus.mem_read), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort.ready_in_reset", 32'(bus.req_ready), 32'd0);
        wrCnt = 0; lat = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.mem_write) wrCnt++;
            if (bus.rsp_valid) lat++;
        end
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.mem_write) wrCnt++;
            if (bus.rsp_valid) lat++;
        end
        checkOutput("abort.writes", 32'(wrCnt), 32'd0);
        checkOutput("abort.rsp_valid", 32'(lat), 32'd0);
        applyStimulus(1'b0, F3_W, 32'h10, 32'h0);
        checkRequest("abort.mem_kept", 3, 1'b0, 1, 0, 32'h5566_AA44);

        checkOutput("strobes_exclusive", 32'(bothSeen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
